// File: rtl/record_serializer.sv
// Serializes one REC_W-bit record per handshake into OUT_W-bit words, MSB first,
// with last/keep qualifiers; also keeps a saturating count of packetLost pulses.
module record_serializer #(
  parameter int REC_W = 296,
  parameter int OUT_W = 32,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               reset_b,
  input  logic [0:REC_W-1]   rec_in,
  input  logic               rec_in_val,
  output logic               rec_in_ready,
  input  logic               packetLost,
  output logic [OUT_W-1:0]   word_out,
  output logic               word_out_val,
  input  logic               word_out_ready,
  output logic               word_out_last,
  output logic [OUT_W/8-1:0] word_out_keep,
  output logic [CNT_W-1:0]   lost_count,
  output logic               busy
);
  localparam int BEATS      = (REC_W + OUT_W - 1) / OUT_W;
  localparam int PAD_W      = BEATS * OUT_W;
  localparam int KEEP_W     = OUT_W / 8;
  localparam int TAIL_BYTES = ((REC_W % OUT_W) == 0) ? KEEP_W : (REC_W % OUT_W) / 8;
  localparam int BEAT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [KEEP_W-1:0] FULL_KEEP = '1;
  localparam logic [KEEP_W-1:0] LAST_KEEP = ~(FULL_KEEP >> TAIL_BYTES);

  typedef enum logic {IDLE, SEND} state_t;

  state_t            state, stateNext;
  logic [BEAT_W-1:0] beat, beatNext;
  logic [PAD_W-1:0]  hold, holdNext, recAligned;
  logic              isLast, recTaken, wordTaken;

  // Record bit 0 sits at the top of the padded hold register; the current
  // word is always the top OUT_W bits, so each beat just shifts left.
  always_comb begin
    recAligned = '0;
    recAligned[PAD_W-1 -: REC_W] = rec_in;
  end

  assign isLast       = (state == SEND) && (beat == LAST_BEAT);
  assign rec_in_ready = (state == IDLE) || (isLast && word_out_ready);

  always_comb begin
    stateNext = state;
    beatNext  = beat;
    holdNext  = hold;
    recTaken  = rec_in_val && rec_in_ready;
    wordTaken = (state == SEND) && word_out_ready;
    if (recTaken) begin
      stateNext = SEND;
      beatNext  = '0;
      holdNext  = recAligned;
    end else if (wordTaken) begin
      if (isLast) begin
        stateNext = IDLE;
        beatNext  = '0;
      end else begin
        beatNext = beat + 1'b1;
        holdNext = hold << OUT_W;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state <= IDLE;
      beat  <= '0;
      hold  <= '0;
    end else begin
      state <= stateNext;
      beat  <= beatNext;
      hold  <= holdNext;
    end
  end

  assign word_out_val  = (state == SEND);
  assign busy          = (state == SEND);
  assign word_out      = (state == SEND) ? hold[PAD_W-1 -: OUT_W] : '0;
  assign word_out_last = isLast;
  assign word_out_keep = isLast ? LAST_KEEP : ((state == SEND) ? FULL_KEEP : '0);

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      lost_count <= '0;
    end else if (packetLost && (lost_count != '1)) begin
      lost_count <= lost_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_record_serializer.sv
// Bench for record_serializer: a word-queue reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_record_serializer;
  localparam int REC_W  = 296;
  localparam int OUT_W  = 32;
  localparam int CNT_W  = 16;
  localparam int KEEP_W = OUT_W / 8;
  localparam int BEATS  = (REC_W + OUT_W - 1) / OUT_W;
  localparam int TAIL   = ((REC_W % OUT_W) == 0) ? KEEP_W : (REC_W % OUT_W) / 8;

  typedef logic [0:REC_W-1] rec_t;
  typedef struct {
    logic [OUT_W-1:0]  w;
    logic              l;
    logic [KEEP_W-1:0] k;
  } beat_t;

  logic clk = 1'b0;
  logic reset_b = 1'b0;
  rec_t rec_in = '0;
  logic rec_in_val = 1'b0;
  logic packetLost = 1'b0;
  logic word_out_ready = 1'b1;
  logic rec_in_ready, word_out_val, word_out_last, busy;
  logic [OUT_W-1:0] word_out;
  logic [KEEP_W-1:0] word_out_keep;
  logic [CNT_W-1:0] lost_count;

  logic d4RecReady, d4Val, d4Last, d4Busy;
  logic [OUT_W-1:0] d4Word;
  logic [KEEP_W-1:0] d4Keep;
  logic [3:0] lost4;

  record_serializer #(.REC_W(REC_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_b(reset_b), .rec_in(rec_in), .rec_in_val(rec_in_val),
    .rec_in_ready(rec_in_ready), .packetLost(packetLost), .word_out(word_out),
    .word_out_val(word_out_val), .word_out_ready(word_out_ready),
    .word_out_last(word_out_last), .word_out_keep(word_out_keep),
    .lost_count(lost_count), .busy(busy)
  );

  record_serializer #(.REC_W(REC_W), .OUT_W(OUT_W), .CNT_W(4)) dut4 (
    .clk(clk), .reset_b(reset_b), .rec_in(rec_in), .rec_in_val(rec_in_val),
    .rec_in_ready(d4RecReady), .packetLost(packetLost), .word_out(d4Word),
    .word_out_val(d4Val), .word_out_ready(word_out_ready),
    .word_out_last(d4Last), .word_out_keep(d4Keep),
    .lost_count(lost4), .busy(d4Busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int validCycles = 0;
  int lostModel = 0;
  int lost4Model = 0;
  beat_t q[$];
  logic [OUT_W-1:0] wordLog[$];
  logic [KEEP_W-1:0] keepLog[$];
  logic lastLog[$];
  int hsCyc[$];
  logic expVal, expReady;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic rec_t mkRec(input int base, input int step);
    rec_t r;
    r = '0;
    for (int i = 0; i < REC_W / 8; i++) r[8*i +: 8] = 8'(base + step * i);
    return r;
  endfunction

  // Word k carries record bits k*OUT_W.. MSB first; bits past the record read as 0.
  function automatic void pushRecord(input rec_t r);
    beat_t b;
    int idx;
    for (int k = 0; k < BEATS; k++) begin
      for (int j = 0; j < OUT_W; j++) begin
        idx = k * OUT_W + j;
        b.w[OUT_W-1-j] = (idx < REC_W) ? r[idx] : 1'b0;
      end
      b.l = (k == BEATS - 1);
      for (int i = 0; i < KEEP_W; i++) b.k[i] = b.l ? (i >= KEEP_W - TAIL) : 1'b1;
      q.push_back(b);
    end
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (!reset_b) begin
      q.delete();
      lostModel = 0;
      lost4Model = 0;
      chk("rst_val", word_out_val, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_word", word_out, '0);
      chk("rst_last", word_out_last, 1'b0);
      chk("rst_keep", word_out_keep, '0);
      chk("rst_lost", lost_count, '0);
    end else begin
      expVal = (q.size() > 0);
      chk("word_out_val", word_out_val, expVal);
      chk("busy", busy, expVal);
      if (expVal) begin
        validCycles++;
        chk("word_out", word_out, q[0].w);
        chk("word_out_last", word_out_last, q[0].l);
        chk("word_out_keep", word_out_keep, q[0].k);
      end
      expReady = (q.size() == 0) || (q.size() == 1 && word_out_ready);
      chk("rec_in_ready", rec_in_ready, expReady);
      chk("lost_count", lost_count, lostModel);
      chk("lost_count4", lost4, lost4Model);
      if (expVal && word_out_ready) begin
        wordLog.push_back(word_out);
        keepLog.push_back(word_out_keep);
        lastLog.push_back(word_out_last);
        hsCyc.push_back(cyc);
        void'(q.pop_front());
      end
      if (rec_in_val && expReady) pushRecord(rec_in);
      if (packetLost) begin
        if (lostModel < 65535) lostModel++;
        if (lost4Model < 15) lost4Model++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitDone(input string name);
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    chk(name, q.size(), 0);
  endtask

  task automatic waitHandshakes(input string name, input int target);
    int n;
    n = 0;
    while (wordLog.size() < target && n < 200) begin
      tick();
      n++;
    end
    chk(name, wordLog.size() >= target, 1'b1);
  endtask

  initial begin
    int base;
    repeat (3) tick();
    reset_b = 1'b1;
    chk("ready_after_reset", rec_in_ready, 1'b1);

    // Single record, bytes 0x01..0x25
    base = wordLog.size();
    rec_in = mkRec(1, 1);
    rec_in_val = 1'b1;
    tick();
    rec_in_val = 1'b0;
    waitDone("single_timeout");
    chk("single_count", wordLog.size() - base, 10);
    chk("single_w0", wordLog[base], 32'h01020304);
    chk("single_w1", wordLog[base+1], 32'h05060708);
    chk("single_w8", wordLog[base+8], 32'h21222324);
    chk("single_w9", wordLog[base+9], 32'h25000000);
    chk("single_keep0", keepLog[base], 4'hF);
    chk("single_keep9", keepLog[base+9], 4'b1000);
    chk("single_last9", lastLog[base+9], 1'b1);
    chk("single_last8", lastLog[base+8], 1'b0);
    tick();
    chk("single_idle", busy, 1'b0);

    // Back-to-back A then B
    base = wordLog.size();
    validCycles = 0;
    rec_in = mkRec(8'h10, 1);
    rec_in_val = 1'b1;
    tick();
    rec_in = mkRec(8'h80, 5);
    waitHandshakes("b2b_timeout", base + 10);
    rec_in_val = 1'b0;
    waitDone("b2b_drain");
    chk("b2b_count", wordLog.size() - base, 20);
    chk("b2b_valid_cycles", validCycles, 20);
    chk("b2b_gap", hsCyc[base+10] - hsCyc[base+9], 1);
    chk("b2b_B_w0", wordLog[base+10], 32'h80858A8F);

    // Backpressure: ready toggles every cycle
    base = wordLog.size();
    validCycles = 0;
    rec_in = mkRec(8'h33, 7);
    rec_in_val = 1'b1;
    word_out_ready = 1'b1;
    tick();
    rec_in_val = 1'b0;
    word_out_ready = 1'b0;
    for (int n = 0; n < 60 && q.size() != 0; n++) begin
      tick();
      word_out_ready = ~word_out_ready;
    end
    chk("bp_timeout", q.size(), 0);
    word_out_ready = 1'b1;
    chk("bp_valid_cycles", validCycles, 20);
    chk("bp_count", wordLog.size() - base, 10);

    // Record offered mid-record
    base = wordLog.size();
    rec_in = mkRec(8'h55, 1);
    rec_in_val = 1'b1;
    tick();
    rec_in_val = 1'b0;
    repeat (4) tick();
    rec_in = mkRec(8'h40, 3);
    rec_in_val = 1'b1;
    #1;
    chk("midrec_not_ready", rec_in_ready, 1'b0);
    waitHandshakes("midrec_timeout", base + 10);
    rec_in_val = 1'b0;
    waitDone("midrec_drain");
    chk("midrec_count", wordLog.size() - base, 20);
    chk("midrec_E_w0", wordLog[base+10], 32'h40434649);

    // Lost-packet counting
    for (int p = 0; p < 3; p++) begin
      packetLost = 1'b1;
      tick();
      packetLost = 1'b0;
      repeat (2) tick();
    end
    chk("lost_3", lost_count, 16'd3);
    chk("lost4_3", lost4, 4'd3);
    rec_in = mkRec(8'hC0, 2);
    rec_in_val = 1'b1;
    packetLost = 1'b1;
    tick();
    rec_in_val = 1'b0;
    repeat (19) tick();
    packetLost = 1'b0;
    tick();
    chk("lost_23", lost_count, 16'd23);
    chk("lost4_sat", lost4, 4'd15);
    packetLost = 1'b1;
    repeat (3) tick();
    packetLost = 1'b0;
    tick();
    chk("lost4_hold", lost4, 4'd15);
    chk("lost_26", lost_count, 16'd26);
    waitDone("lost_drain");

    // Reset in the middle of a record
    rec_in = mkRec(8'hE0, 1);
    rec_in_val = 1'b1;
    tick();
    rec_in_val = 1'b0;
    repeat (5) tick();
    #2;
    reset_b = 1'b0;
    #1;
    chk("mrst_val", word_out_val, 1'b0);
    chk("mrst_word", word_out, '0);
    chk("mrst_last", word_out_last, 1'b0);
    chk("mrst_keep", word_out_keep, '0);
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_lost", lost_count, '0);
    repeat (2) tick();
    reset_b = 1'b1;
    chk("mrst_ready", rec_in_ready, 1'b1);
    base = wordLog.size();
    rec_in = mkRec(8'hA0, 1);
    rec_in_val = 1'b1;
    tick();
    rec_in_val = 1'b0;
    waitDone("mrst_timeout");
    chk("mrst_count", wordLog.size() - base, 10);
    chk("mrst_w0", wordLog[base], 32'hA0A1A2A3);
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
